// File: rtl/watch_pkg.sv
// Shared types and constants for the watch/alarm controller.
// Pure declarations and helper functions; no timing of its own.
// No flow control: every consumer samples these constants directly.
package watch_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_SET_H = 3'd1,
    ST_SET_M = 3'd2,
    ST_SET_S = 3'd3,
    ST_ALM_H = 3'd4,
    ST_ALM_M = 3'd5
  } state_t;

  // Field ranges: hours wrap at 23, minutes/seconds at 59.
  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MS_MAX   = 6'd59;

  // Digit word layout is {enable, bcd[3:0], dp}.
  localparam logic [5:0] DIGIT_BLANK = 6'b0_0000_1;
  localparam logic [5:0] DIGIT_ZERO  = 6'b1_0000_1;
  localparam logic [5:0] SEP_WORD    = 6'b0_0000_1;

  // Increment or decrement a field value, wrapping inside 0..max_val.
  function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max_val,
                                           input logic up);
    if (up) return (val >= max_val) ? 6'd0 : val + 6'd1;
    else    return (val == 6'd0) ? max_val : val - 6'd1;
  endfunction

  // 24 h hour to 12 h display hour: 0 -> 12, 13..23 -> 1..11.
  function automatic logic [5:0] to_12h(input logic [5:0] hour);
    if (hour == 6'd0)       return 6'd12;
    else if (hour > 6'd12)  return hour - 6'd12;
    else                    return hour;
  endfunction

  function automatic logic [5:0] digit_word(input logic en, input logic [3:0] bcd);
    return {en, bcd, 1'b1};
  endfunction

endpackage

// File: rtl/watch_alarm_ctrl_bcd_split.sv
// Binary 0..59 to two BCD digits (tens, units).
// Purely combinational, zero latency.
// No flow control.
module bcd_split (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  // Range-compare ladder instead of a divider; inputs never exceed 59.
  always_comb begin
    tens  = 4'd0;
    units = bin[3:0];
    if (bin >= 6'd50) begin
      tens  = 4'd5;
      units = 4'(bin - 6'd50);
    end else if (bin >= 6'd40) begin
      tens  = 4'd4;
      units = 4'(bin - 6'd40);
    end else if (bin >= 6'd30) begin
      tens  = 4'd3;
      units = 4'(bin - 6'd30);
    end else if (bin >= 6'd20) begin
      tens  = 4'd2;
      units = 4'(bin - 6'd20);
    end else if (bin >= 6'd10) begin
      tens  = 4'd1;
      units = 4'(bin - 6'd10);
    end
  end

endmodule

// File: rtl/watch_alarm_ctrl.sv
// Watch timekeeping, time/alarm setting FSM, alarm ringer and digit-word generation.
// Strobe to state: 1 cycle; strobe to d*/pm: 2 cycles; strobe to alarm_active: 1 cycle.
// No backpressure: strobes and button presses are consumed in the cycle they arrive.
module watch_alarm_ctrl
  import watch_pkg::*;
#(
  parameter int SET_TIMEOUT_S = 30,
  parameter int ALARM_RING_S  = 60,
  parameter int ALARM_RST_H   = 6,
  parameter int ALARM_RST_M   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulse_1hz,
  input  logic       pulse_500ms,
  input  logic       mode_button,
  input  logic       add_button,
  input  logic       sub_button,
  input  logic       alarm_en,
  input  logic       mode_12h,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic [5:0] d5,
  output logic [5:0] d6,
  output logic [5:0] d7,
  output logic [5:0] d8,
  output logic       pm,
  output logic       alarm_active
);

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt, tmo_nxt, ring_cnt;
  logic [4:0]  hour, alm_h, hour_inc;
  logic [5:0]  min, sec, alm_m, min_inc, sec_inc;
  logic        blink;
  logic        press, do_mode, do_add, do_sub, do_edit, time_run, tick, trigger;

  // A press while ringing only silences the alarm; otherwise mode > add > sub.
  assign press    = mode_button | add_button | sub_button;
  assign do_mode  = mode_button & ~alarm_active;
  assign do_add   = add_button & ~mode_button & ~alarm_active;
  assign do_sub   = sub_button & ~add_button & ~mode_button & ~alarm_active;
  assign do_edit  = do_add | do_sub;
  assign time_run = (state == ST_RUN) || (state == ST_ALM_H) || (state == ST_ALM_M);
  assign tick     = pulse_1hz & time_run;

  // Next state and inactivity timeout: presses clear the timer, 1 Hz ticks outside RUN advance it.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    if (press) begin
      tmo_nxt = '0;
      if (do_mode) begin
        case (state)
          ST_RUN:   state_nxt = ST_SET_H;
          ST_SET_H: state_nxt = ST_SET_M;
          ST_SET_M: state_nxt = ST_SET_S;
          ST_SET_S: state_nxt = ST_ALM_H;
          ST_ALM_H: state_nxt = ST_ALM_M;
          default:  state_nxt = ST_RUN;
        endcase
      end
    end else if (state != ST_RUN && pulse_1hz) begin
      if (SET_TIMEOUT_S > 0 && (tmo_cnt + 16'd1) >= 16'(SET_TIMEOUT_S)) begin
        state_nxt = ST_RUN;
        tmo_nxt   = '0;
      end else begin
        tmo_nxt = tmo_cnt + 16'd1;
      end
    end
  end

  // State and timeout register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_RUN;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  // Time one second ahead, with seconds -> minutes -> hours carry.
  always_comb begin
    sec_inc  = (sec == MS_MAX) ? 6'd0 : sec + 6'd1;
    min_inc  = min;
    hour_inc = hour;
    if (sec == MS_MAX) begin
      min_inc = (min == MS_MAX) ? 6'd0 : min + 6'd1;
      if (min == MS_MAX) hour_inc = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    end
  end

  assign trigger = tick & alarm_en & (sec_inc == 6'd0) & (min_inc == alm_m) & (hour_inc == alm_h);

  // Time of day: edited in SET_* (frozen there), otherwise advanced by the 1 Hz tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hour <= '0;
      min  <= '0;
      sec  <= '0;
    end else if (do_edit && state == ST_SET_H) begin
      hour <= 5'(wrap_step({1'b0, hour}, HOUR_MAX, do_add));
    end else if (do_edit && state == ST_SET_M) begin
      min  <= wrap_step(min, MS_MAX, do_add);
    end else if (do_edit && state == ST_SET_S) begin
      sec  <= wrap_step(sec, MS_MAX, do_add);
    end else if (tick) begin
      hour <= hour_inc;
      min  <= min_inc;
      sec  <= sec_inc;
    end
  end

  // Alarm time: only edited in ALM_*, independent of the running clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alm_h <= 5'(ALARM_RST_H);
      alm_m <= 6'(ALARM_RST_M);
    end else if (do_edit && state == ST_ALM_H) begin
      alm_h <= 5'(wrap_step({1'b0, alm_h}, HOUR_MAX, do_add));
    end else if (do_edit && state == ST_ALM_M) begin
      alm_m <= wrap_step(alm_m, MS_MAX, do_add);
    end
  end

  // Ringer: a fresh match wins; silencing, disarm or ring expiry end it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alarm_active <= 1'b0;
      ring_cnt     <= '0;
    end else if (trigger) begin
      alarm_active <= 1'b1;
      ring_cnt     <= 16'(ALARM_RING_S);
    end else if (!alarm_en || (press && alarm_active)) begin
      alarm_active <= 1'b0;
      ring_cnt     <= '0;
    end else if (alarm_active && pulse_1hz) begin
      if (ring_cnt <= 16'd1) begin
        alarm_active <= 1'b0;
        ring_cnt     <= '0;
      end else begin
        ring_cnt <= ring_cnt - 16'd1;
      end
    end
  end

  // Blink phase for edited fields and ringing display.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           blink <= 1'b1;
    else if (pulse_500ms) blink <= ~blink;
  end

  logic [5:0] hour_disp, alm_disp;
  logic [3:0] th_t, th_u, tm_t, tm_u, ts_t, ts_u, ah_t, ah_u, am_t, am_u;

  assign hour_disp = mode_12h ? to_12h({1'b0, hour})  : {1'b0, hour};
  assign alm_disp  = mode_12h ? to_12h({1'b0, alm_h}) : {1'b0, alm_h};

  bcd_split u_bcd_th (.bin(hour_disp), .tens(th_t), .units(th_u));
  bcd_split u_bcd_tm (.bin(min),       .tens(tm_t), .units(tm_u));
  bcd_split u_bcd_ts (.bin(sec),       .tens(ts_t), .units(ts_u));
  bcd_split u_bcd_ah (.bin(alm_disp),  .tens(ah_t), .units(ah_u));
  bcd_split u_bcd_am (.bin(alm_m),     .tens(am_t), .units(am_u));

  logic       show_alm, en_h, en_m, en_s, pm_nxt;
  logic [5:0] d8_nxt, d7_nxt, d5_nxt, d4_nxt, d2_nxt, d1_nxt;

  // Digit words: alarm view hides seconds, edited field blinks, ringing blinks everything.
  always_comb begin
    show_alm = (state == ST_ALM_H) || (state == ST_ALM_M);
    en_h     = 1'b1;
    en_m     = 1'b1;
    en_s     = 1'b1;
    if (state == ST_SET_H || state == ST_ALM_H) en_h = blink;
    if (state == ST_SET_M || state == ST_ALM_M) en_m = blink;
    if (state == ST_SET_S)                      en_s = blink;
    if (alarm_active) begin
      en_h = blink;
      en_m = blink;
      en_s = blink;
    end
    d8_nxt = digit_word(en_h, show_alm ? ah_t : th_t);
    d7_nxt = digit_word(en_h, show_alm ? ah_u : th_u);
    d5_nxt = digit_word(en_m, show_alm ? am_t : tm_t);
    d4_nxt = digit_word(en_m, show_alm ? am_u : tm_u);
    d2_nxt = show_alm ? DIGIT_BLANK : digit_word(en_s, ts_t);
    d1_nxt = show_alm ? DIGIT_BLANK : digit_word(en_s, ts_u);
    pm_nxt = mode_12h & ((show_alm ? alm_h : hour) >= 5'd12);
  end

  assign d6 = SEP_WORD;
  assign d3 = SEP_WORD;

  // Registered display outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d8 <= DIGIT_ZERO;
      d7 <= DIGIT_ZERO;
      d5 <= DIGIT_ZERO;
      d4 <= DIGIT_ZERO;
      d2 <= DIGIT_ZERO;
      d1 <= DIGIT_ZERO;
      pm <= 1'b0;
    end else begin
      d8 <= d8_nxt;
      d7 <= d7_nxt;
      d5 <= d5_nxt;
      d4 <= d4_nxt;
      d2 <= d2_nxt;
      d1 <= d1_nxt;
      pm <= pm_nxt;
    end
  end

endmodule

// File: tb/tb_watch_alarm_ctrl.sv
// Directed bench for watch_alarm_ctrl with a seconds-of-day reference model.
// The model is stepped once per clock edge; a negedge process compares all outputs.
module tb_watch_alarm_ctrl;

  localparam int TMO  = 30;
  localparam int RING = 60;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pulse_1hz = 1'b0, pulse_500ms = 1'b0;
  logic       mode_button = 1'b0, add_button = 1'b0, sub_button = 1'b0;
  logic       alarm_en = 1'b0, mode_12h = 1'b0;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       pm, alarm_active;

  always #5 clock = ~clock;

  watch_alarm_ctrl #(
    .SET_TIMEOUT_S(TMO), .ALARM_RING_S(RING), .ALARM_RST_H(6), .ALARM_RST_M(0)
  ) dut (
    .clock(clock), .reset(reset), .pulse_1hz(pulse_1hz), .pulse_500ms(pulse_500ms),
    .mode_button(mode_button), .add_button(add_button), .sub_button(sub_button),
    .alarm_en(alarm_en), .mode_12h(mode_12h),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .pm(pm), .alarm_active(alarm_active)
  );

  int tests = 0;
  int fails = 0;

  // Model: state index (0 RUN,1..3 SET_H/M/S,4..5 ALM_H/M), time in seconds of day,
  // alarm in minutes of day.
  int   m_st, m_t, m_a, m_tmo, m_ring;
  bit   m_blink, m_act;
  logic [5:0] e_d [1:8];
  logic [5:0] got [1:8];
  logic e_pm, e_act;
  bit   chk_en = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expect_v);
    tests++;
    if (actual !== expect_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expect_v, $time);
    end
  endtask

  function automatic logic [5:0] word(input bit en, input int v);
    return {en, v[3:0], 1'b1};
  endfunction

  task automatic model_reset();
    m_st = 0; m_t = 0; m_a = 6 * 60; m_tmo = 0; m_ring = 0; m_blink = 1; m_act = 0;
    for (int i = 1; i <= 8; i++) e_d[i] = 6'b100001;
    e_d[6] = 6'b000001;
    e_d[3] = 6'b000001;
    e_pm = 0; e_act = 0;
  endtask

  task automatic model_step(input bit md, input bit ad, input bit sb, input bit p1, input bit p5);
    int h, mi, s, hh, n_st, n_t, n_a, n_tmo, n_ring, dl;
    bit alm, enh, enm, ens, n_act, adv, trig, npm;
    logic [5:0] nd [1:8];
    // display registered from the pre-edge state
    alm = (m_st >= 4);
    h   = alm ? m_a / 60 : m_t / 3600;
    mi  = alm ? m_a % 60 : (m_t / 60) % 60;
    s   = m_t % 60;
    hh  = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    enh = (m_st == 1 || m_st == 4) ? m_blink : 1'b1;
    enm = (m_st == 2 || m_st == 5) ? m_blink : 1'b1;
    ens = (m_st == 3) ? m_blink : 1'b1;
    if (m_act) begin enh = m_blink; enm = m_blink; ens = m_blink; end
    nd[8] = word(enh, hh / 10);
    nd[7] = word(enh, hh % 10);
    nd[6] = 6'b000001;
    nd[5] = word(enm, mi / 10);
    nd[4] = word(enm, mi % 10);
    nd[3] = 6'b000001;
    nd[2] = alm ? 6'b000001 : word(ens, s / 10);
    nd[1] = alm ? 6'b000001 : word(ens, s % 10);
    npm   = mode_12h && (h >= 12);
    // behavioural state update
    n_st = m_st; n_t = m_t; n_a = m_a; n_tmo = m_tmo; n_ring = m_ring; n_act = m_act;
    adv  = p1 && !(m_st >= 1 && m_st <= 3);
    if (adv) n_t = (m_t + 1) % 86400;
    trig = adv && alarm_en && (n_t % 60 == 0) && (n_t / 60 == m_a);
    if (md || ad || sb) begin
      n_tmo = 0;
      if (m_act) begin
        n_act = 0; n_ring = 0;
      end else if (md) begin
        n_st = (m_st + 1) % 6;
      end else if (m_st != 0) begin
        dl = ad ? 1 : -1;
        case (m_st)
          1: n_t = ((m_t / 3600 + dl + 24) % 24) * 3600 + m_t % 3600;
          2: n_t = (m_t / 3600) * 3600 + (((m_t / 60) % 60 + dl + 60) % 60) * 60 + m_t % 60;
          3: n_t = m_t - m_t % 60 + (m_t % 60 + dl + 60) % 60;
          4: n_a = ((m_a / 60 + dl + 24) % 24) * 60 + m_a % 60;
          default: n_a = (m_a / 60) * 60 + (m_a % 60 + dl + 60) % 60;
        endcase
      end
    end else begin
      if (m_st != 0 && p1) begin
        n_tmo = m_tmo + 1;
        if (TMO > 0 && n_tmo >= TMO) begin n_st = 0; n_tmo = 0; end
      end
      if (m_act && p1) begin
        if (m_ring <= 1) begin n_act = 0; n_ring = 0; end
        else n_ring = m_ring - 1;
      end
    end
    if (!alarm_en) begin n_act = 0; n_ring = 0; end
    if (trig) begin n_act = 1; n_ring = RING; end
    m_st = n_st; m_t = n_t; m_a = n_a; m_tmo = n_tmo; m_ring = n_ring; m_act = n_act;
    if (p5) m_blink = !m_blink;
    e_d = nd; e_pm = npm; e_act = n_act;
  endtask

  task automatic step_edge(input bit md, input bit ad, input bit sb, input bit p1, input bit p5);
    @(posedge clock);
    model_step(md, ad, sb, p1, p5);
    #1;
    mode_button = 0; add_button = 0; sub_button = 0; pulse_1hz = 0; pulse_500ms = 0;
  endtask

  task automatic cyc(input bit md, input bit ad, input bit sb, input bit p1, input bit p5);
    @(negedge clock);
    mode_button = md; add_button = ad; sub_button = sb; pulse_1hz = p1; pulse_500ms = p5;
    step_edge(md, ad, sb, p1, p5);
  endtask

  task automatic idle2();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  // From RUN: walk SET_H/M/S with add presses to reach h:mi:s, then back to RUN.
  task automatic set_time(input int h, input int mi, input int s);
    int nh, nm, ns;
    nh = (h - m_t / 3600 + 24) % 24;
    nm = (mi - (m_t / 60) % 60 + 60) % 60;
    ns = (s - m_t % 60 + 60) % 60;
    cyc(1, 0, 0, 0, 0);
    repeat (nh) cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (nm) cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (ns) cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      got[1] = d1; got[2] = d2; got[3] = d3; got[4] = d4;
      got[5] = d5; got[6] = d6; got[7] = d7; got[8] = d8;
      for (int i = 1; i <= 8; i++) check($sformatf("cmp_d%0d", i), 32'(got[i]), 32'(e_d[i]));
      check("cmp_pm", 32'(pm), 32'(e_pm));
      check("cmp_alarm_active", 32'(alarm_active), 32'(e_act));
    end
  end

  int t0;

  initial begin
    // reset state
    reset = 0;
    model_reset();
    chk_en = 1;
    #12;
    check("rst_d8", 32'(d8), 32'h21);
    check("rst_d6", 32'(d6), 32'h01);
    check("rst_d1", 32'(d1), 32'h21);
    check("rst_pm", 32'(pm), 0);
    check("rst_alarm", 32'(alarm_active), 0);
    @(negedge clock);
    reset = 1;
    step_edge(0, 0, 0, 0, 0);

    // 61 seconds in RUN -> 00:01:01
    repeat (61) cyc(0, 0, 0, 1, 0);
    idle2();
    check("model_t61", m_t, 61);
    check("t61_d4", 32'(d4), 32'b100011);
    check("t61_d2", 32'(d2), 32'b100001);
    check("t61_d1", 32'(d1), 32'b100011);

    // SET_H wrap and same-cycle priority
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle2();
    check("seth_sub_d8", 32'(d8), 32'b100101);
    check("seth_sub_d7", 32'(d7), 32'b100111);
    cyc(0, 1, 0, 0, 0);
    idle2();
    check("seth_add_d7", 32'(d7), 32'b100001);
    cyc(0, 1, 1, 0, 0);
    idle2();
    check("seth_addsub_d7", 32'(d7), 32'b100011);
    check("model_h1", m_t / 3600, 1);

    // preload 23:59:59, back to RUN, roll over
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    idle2();
    check("model_235959", m_t, 86399);
    check("pre_roll_d8", 32'(d8), 32'b100101);
    check("pre_roll_d2", 32'(d2), 32'b101011);
    check("pre_roll_d1", 32'(d1), 32'b110011);
    cyc(0, 0, 0, 1, 0);
    idle2();
    check("roll_d8", 32'(d8), 32'b100001);
    check("roll_d5", 32'(d5), 32'b100001);
    check("roll_d1", 32'(d1), 32'b100001);

    // alarm 06:00 trigger and silence by press
    alarm_en = 1;
    set_time(5, 59, 59);
    cyc(0, 0, 0, 1, 0);
    check("alarm_rise", 32'(alarm_active), 1);
    check("model_alarm_rise", 32'(m_act), 1);
    cyc(0, 0, 0, 0, 1);
    idle2();
    check("ring_blink_d8", 32'(d8), 32'b000001);
    check("ring_blink_d7", 32'(d7), 32'b001101);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    check("silence", 32'(alarm_active), 0);
    check("silence_state", m_st, 0);
    check("silence_time", m_t, 6 * 3600);
    idle2();
    check("silence_d7", 32'(d7), 32'b101101);

    // ring expiry after RING seconds
    set_time(5, 59, 59);
    cyc(0, 0, 0, 1, 0);
    repeat (RING - 1) cyc(0, 0, 0, 1, 0);
    check("ring_still", 32'(alarm_active), 1);
    cyc(0, 0, 0, 1, 0);
    check("ring_expired", 32'(alarm_active), 0);

    // disarm while ringing
    set_time(5, 59, 59);
    cyc(0, 0, 0, 1, 0);
    check("rearm_rise", 32'(alarm_active), 1);
    alarm_en = 0;
    cyc(0, 0, 0, 0, 0);
    check("disarm_clear", 32'(alarm_active), 0);

    // timeout out of SET_M
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    t0 = m_t;
    check("tmo_t0", t0, 6 * 3600);
    repeat (TMO - 1) cyc(0, 0, 0, 1, 0);
    check("tmo_still_setm", m_st, 2);
    cyc(0, 0, 0, 1, 0);
    check("tmo_to_run", m_st, 0);
    check("tmo_frozen", m_t, 6 * 3600);
    cyc(0, 0, 0, 1, 0);
    check("tmo_resume", m_t, 6 * 3600 + 1);
    idle2();
    check("tmo_d4", 32'(d4), 32'b100001);
    check("tmo_d1", 32'(d1), 32'b100011);
    cyc(0, 0, 0, 0, 1);

    // 12 h display
    mode_12h = 1;
    set_time(13, 5, 0);
    idle2();
    check("h13_d8", 32'(d8), 32'b100001);
    check("h13_d7", 32'(d7), 32'b100011);
    check("h13_pm", 32'(pm), 1);
    set_time(0, 10, 0);
    idle2();
    check("h00_d8", 32'(d8), 32'b100011);
    check("h00_d7", 32'(d7), 32'b100101);
    check("h00_pm", 32'(pm), 0);

    // asynchronous reset mid-operation
    set_time(15, 0, 0);
    idle2();
    @(posedge clock);
    #3;
    reset = 0;
    model_reset();
    #1;
    check("arst_d7", 32'(d7), 32'b100001);
    check("arst_d5", 32'(d5), 32'b100001);
    check("arst_pm", 32'(pm), 0);
    check("arst_alarm", 32'(alarm_active), 0);
    @(negedge clock);
    reset = 1;
    step_edge(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("post_rst_12h_d8", 32'(d8), 32'b100011);
    check("post_rst_pm", 32'(pm), 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
